// File: rtl/sm_timer_pkg.sv
// Shared constants and helpers for the sm_timer compare timer: default bus
// base, register offsets, CTRL bit positions and the CTRL read-back packer.
package sm_timer_pkg;

    localparam logic [11:0] SM_TIMER_BASE    = 12'hbec;
    localparam int          SM_TIMER_PRESC_W = 16;

    // Register offsets as seen in bAddr[3:2]
    typedef enum logic [1:0] {
        REG_CTRL  = 2'd0,
        REG_PRESC = 2'd1,
        REG_CMP   = 2'd2,
        REG_CNT   = 2'd3
    } reg_off_e;

    // CTRL bit positions
    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_ONESHOT_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;
    localparam int CTRL_MATCH_BIT   = 8;

    // Assemble the CTRL read word; unassigned bits read as zero
    function automatic logic [31:0] ctrl_pack(input logic en,
                                              input logic oneshot,
                                              input logic irq_en,
                                              input logic match);
        logic [31:0] word;
        word                   = 32'h0000_0000;
        word[CTRL_EN_BIT]      = en;
        word[CTRL_ONESHOT_BIT] = oneshot;
        word[CTRL_IRQ_EN_BIT]  = irq_en;
        word[CTRL_MATCH_BIT]   = match;
        return word;
    endfunction

endpackage

// File: rtl/sm_timer_prescaler.sv
// Prescaler for sm_timer: counts 0..presc while enabled and emits a tick on
// the terminal count. Held at zero while disabled; clr restarts the count.
module sm_timer_prescaler
    import sm_timer_pkg::*;
#(
    parameter int PRESC_W = SM_TIMER_PRESC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt_r;
    logic [PRESC_W-1:0] pcnt_nxt;
    logic               hit_s;

    assign hit_s = (pcnt_r == presc);
    assign tick  = en & hit_s;

    // Next prescale count: restart on clear, disable or terminal count
    always_comb begin
        pcnt_nxt = pcnt_r;
        if (clr || !en || hit_s) begin
            pcnt_nxt = {PRESC_W{1'b0}};
        end else begin
            pcnt_nxt = pcnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

    // Prescale count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_r <= {PRESC_W{1'b0}};
        end else begin
            pcnt_r <= pcnt_nxt;
        end
    end

endmodule

// File: rtl/sm_timer.sv
// sm_timer: memory-mapped 32-bit compare timer on the sm_matrix bus.
// Prescaled up-counter with compare match, one-shot / auto-reload modes,
// a sticky write-1-to-clear MATCH flag and a registered level irq.
module sm_timer
    import sm_timer_pkg::*;
#(
    parameter logic [11:0] BASE    = SM_TIMER_BASE,
    parameter int          PRESC_W = SM_TIMER_PRESC_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bAddr,
    input  logic        bWe,
    input  logic [31:0] bWData,
    output logic [31:0] bRData,
    output logic        irq,
    output logic        match_pulse
);

    // Bus decode
    logic     sel_s;
    reg_off_e off_s;
    logic     wr_ctrl_s;
    logic     wr_presc_s;
    logic     wr_cmp_s;
    logic     wr_cnt_s;
    logic     unused_addr_s;

    // Architectural state
    logic               en_r;
    logic               oneshot_r;
    logic               irq_en_r;
    logic               match_r;
    logic [PRESC_W-1:0] presc_r;
    logic [31:0]        cmp_r;
    logic [31:0]        cnt_r;
    logic               irq_r;
    logic               pulse_r;

    // Next-state values
    logic               en_nxt;
    logic               oneshot_nxt;
    logic               irq_en_nxt;
    logic               match_nxt;
    logic [PRESC_W-1:0] presc_nxt;
    logic [31:0]        cmp_nxt;
    logic [31:0]        cnt_nxt;
    logic               irq_nxt;
    logic               pulse_nxt;

    logic        tick_s;
    logic        match_ev_s;
    logic        en_wr_s;
    logic [31:0] rdata_s;

    assign sel_s      = (bAddr[15:4] == BASE);
    assign off_s      = reg_off_e'(bAddr[3:2]);
    assign wr_ctrl_s  = sel_s & bWe & (off_s == REG_CTRL);
    assign wr_presc_s = sel_s & bWe & (off_s == REG_PRESC);
    assign wr_cmp_s   = sel_s & bWe & (off_s == REG_CMP);
    assign wr_cnt_s   = sel_s & bWe & (off_s == REG_CNT);

    // Address bits outside the decode window are intentionally ignored
    assign unused_addr_s = &{1'b0, bAddr[31:16], bAddr[1:0]};

    sm_timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (en_r),
        .presc (presc_r),
        .clr   (wr_presc_s),
        .tick  (tick_s)
    );

    // A CPU write to CNT on a tick edge suppresses that edge's compare
    assign match_ev_s = tick_s & ~wr_cnt_s & (cnt_r == cmp_r);
    assign en_wr_s    = wr_ctrl_s ? bWData[CTRL_EN_BIT] : en_r;

    // Next-state logic for control bits, prescaler, compare and counter
    always_comb begin
        oneshot_nxt = oneshot_r;
        irq_en_nxt  = irq_en_r;
        en_nxt      = en_r;
        match_nxt   = match_r;
        presc_nxt   = presc_r;
        cmp_nxt     = cmp_r;
        cnt_nxt     = cnt_r;
        pulse_nxt   = 1'b0;
        irq_nxt     = 1'b0;

        if (wr_ctrl_s) begin
            oneshot_nxt = bWData[CTRL_ONESHOT_BIT];
            irq_en_nxt  = bWData[CTRL_IRQ_EN_BIT];
        end else begin
            oneshot_nxt = oneshot_r;
            irq_en_nxt  = irq_en_r;
        end

        // One-shot hardware disable beats a software EN=1 on the same edge
        if (match_ev_s && oneshot_r) begin
            en_nxt = 1'b0;
        end else begin
            en_nxt = en_wr_s;
        end

        // Hardware set beats write-1-to-clear on the same edge
        if (match_ev_s) begin
            match_nxt = 1'b1;
        end else if (wr_ctrl_s && bWData[CTRL_MATCH_BIT]) begin
            match_nxt = 1'b0;
        end else begin
            match_nxt = match_r;
        end

        if (wr_presc_s) begin
            presc_nxt = bWData[PRESC_W-1:0];
        end else begin
            presc_nxt = presc_r;
        end

        if (wr_cmp_s) begin
            cmp_nxt = bWData;
        end else begin
            cmp_nxt = cmp_r;
        end

        // Software write wins over the tick; wrap past all-ones is silent
        if (wr_cnt_s) begin
            cnt_nxt = bWData;
        end else if (match_ev_s) begin
            cnt_nxt = 32'h0000_0000;
        end else if (tick_s) begin
            cnt_nxt = cnt_r + 32'd1;
        end else begin
            cnt_nxt = cnt_r;
        end

        pulse_nxt = match_ev_s;
        irq_nxt   = match_nxt & irq_en_nxt;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r      <= 1'b0;
            oneshot_r <= 1'b0;
            irq_en_r  <= 1'b0;
            match_r   <= 1'b0;
            presc_r   <= {PRESC_W{1'b0}};
            cmp_r     <= 32'h0000_0000;
            cnt_r     <= 32'h0000_0000;
            irq_r     <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            en_r      <= en_nxt;
            oneshot_r <= oneshot_nxt;
            irq_en_r  <= irq_en_nxt;
            match_r   <= match_nxt;
            presc_r   <= presc_nxt;
            cmp_r     <= cmp_nxt;
            cnt_r     <= cnt_nxt;
            irq_r     <= irq_nxt;
            pulse_r   <= pulse_nxt;
        end
    end

    // Zero-latency read mux; unselected reads return zero
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (sel_s) begin
            case (off_s)
                REG_CTRL:  rdata_s = ctrl_pack(en_r, oneshot_r, irq_en_r, match_r);
                REG_PRESC: rdata_s = 32'(presc_r);
                REG_CMP:   rdata_s = cmp_r;
                REG_CNT:   rdata_s = cnt_r;
                default:   rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign bRData      = rdata_s;
    assign irq         = irq_r;
    assign match_pulse = pulse_r;

endmodule

// File: tb/tb_sm_timer.sv
// Self-checking bench for sm_timer: expected values are queued as stimulus
// is applied and popped when the DUT output is sampled.
module tb_sm_timer;
    import sm_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bAddr = 32'h0;
    logic        bWe = 1'b0;
    logic [31:0] bWData = 32'h0;
    logic [31:0] bRData;
    logic        irq;
    logic        match_pulse;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic        exp_p_q[$];

    sm_timer dut (
        .clk         (clk),
        .rst         (rst),
        .bAddr       (bAddr),
        .bWe         (bWe),
        .bWData      (bWData),
        .bRData      (bRData),
        .irq         (irq),
        .match_pulse (match_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addr_of(input logic [1:0] off);
        return {16'h0000, SM_TIMER_BASE, off, 2'b00};
    endfunction

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        @(negedge clk);
        bAddr  = addr_of(off);
        bWData = d;
        bWe    = 1'b1;
        @(posedge clk);
        #1;
        bWe    = 1'b0;
        bWData = 32'h0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        bAddr = addr_of(off);
        #1;
        d = bRData;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] e;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            rd(i[1:0], v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL reset_read off=%0d got=%h exp=%h", i, v, e);
            end
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        checks++;
        if (match_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_pulse got=%b exp=0", match_pulse);
        end
    endtask

    task automatic test_basic_match;
        logic [31:0] v;
        logic [31:0] e;
        logic        ep;
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h3);
        // CMP holds 3, so a bad decode of a neighbouring base would show it
        bAddr = {16'h0000, 12'hbed, 2'b10, 2'b00};
        #1;
        checks++;
        if (bRData !== 32'h0) begin
            failures++;
            $display("FAIL outside_base got=%h exp=00000000", bRData);
        end
        wr(2'd0, 32'h5);
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(32'(k % 4));
            exp_p_q.push_back(k == 4);
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            rd(2'd3, v);
            e  = exp_q.pop_front();
            ep = exp_p_q.pop_front();
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL basic_cnt k=%0d got=%h exp=%h", k, v, e);
            end
            checks++;
            if (match_pulse !== ep) begin
                failures++;
                $display("FAIL basic_pulse k=%0d got=%b exp=%b", k, match_pulse, ep);
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h105) begin
            failures++;
            $display("FAIL basic_ctrl_match got=%h exp=00000105", v);
        end
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL basic_irq_set got=%b exp=1", irq);
        end
        wr(2'd0, 32'h105);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h5) begin
            failures++;
            $display("FAIL basic_w1c got=%h exp=00000005", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL basic_irq_clr got=%b exp=0", irq);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h1) begin
            failures++;
            $display("FAIL basic_continue got=%h exp=00000001", v);
        end
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0);
    endtask

    task automatic test_prescaler;
        logic [31:0] v;
        logic [31:0] e;
        logic        ep;
        wr(2'd1, 32'h2);
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            exp_q.push_back(32'((k / 3) % 2));
            exp_p_q.push_back((k == 6) || (k == 12));
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            rd(2'd3, v);
            e  = exp_q.pop_front();
            ep = exp_p_q.pop_front();
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL presc_cnt k=%0d got=%h exp=%h", k, v, e);
            end
            checks++;
            if (match_pulse !== ep) begin
                failures++;
                $display("FAIL presc_pulse k=%0d got=%b exp=%b", k, match_pulse, ep);
            end
        end
        // Let the prescale count advance to 1, then rewrite PRESC
        @(posedge clk);
        wr(2'd1, 32'h4);
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back((k == 5) ? 32'h1 : 32'h0);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            rd(2'd3, v);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL presc_restart k=%0d got=%h exp=%h", k, v, e);
            end
        end
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0);
        wr(2'd1, 32'h0);
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        logic [31:0] e;
        logic        ep;
        wr(2'd2, 32'h2);
        wr(2'd0, 32'h100);
        wr(2'd0, 32'h3);
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h2);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int k = 1; k <= 5; k++) exp_p_q.push_back(k == 3);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            rd(2'd3, v);
            e  = exp_q.pop_front();
            ep = exp_p_q.pop_front();
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL oneshot_cnt k=%0d got=%h exp=%h", k, v, e);
            end
            checks++;
            if (match_pulse !== ep) begin
                failures++;
                $display("FAIL oneshot_pulse k=%0d got=%b exp=%b", k, match_pulse, ep);
            end
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h102) begin
            failures++;
            $display("FAIL oneshot_ctrl got=%h exp=00000102", v);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] v;
        logic [31:0] e;
        logic [31:0] c;
        wr(2'd0, 32'h100);
        wr(2'd2, 32'h5);
        wr(2'd3, 32'hFFFF_FFFE);
        wr(2'd0, 32'h1);
        exp_q.push_back(32'hFFFF_FFFF);
        for (int k = 0; k <= 5; k++) exp_q.push_back(32'(k));
        exp_q.push_back(32'h0);
        for (int k = 1; k <= 8; k++) exp_p_q.push_back(k == 8);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            rd(2'd3, v);
            rd(2'd0, c);
            e = exp_q.pop_front();
            checks++;
            if (v !== e) begin
                failures++;
                $display("FAIL wrap_cnt k=%0d got=%h exp=%h", k, v, e);
            end
            e[0] = exp_p_q.pop_front();
            checks++;
            if (c[8] !== e[0]) begin
                failures++;
                $display("FAIL wrap_match k=%0d got=%b exp=%b", k, c[8], e[0]);
            end
        end
        wr(2'd0, 32'h0);
    endtask

    task automatic test_collisions;
        logic [31:0] v;
        logic [31:0] e;
        wr(2'd0, 32'h100);
        wr(2'd3, 32'h0);
        wr(2'd2, 32'd100);
        wr(2'd0, 32'h1);
        repeat (2) @(posedge clk);
        wr(2'd3, 32'h10);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h11);
        rd(2'd3, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL tick_cnt_write got=%h exp=%h", v, e);
        end
        @(posedge clk);
        #1;
        rd(2'd3, v);
        e = exp_q.pop_front();
        checks++;
        if (v !== e) begin
            failures++;
            $display("FAIL tick_cnt_after got=%h exp=%h", v, e);
        end
        // W1C landing on the match edge
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h0);
        wr(2'd2, 32'h3);
        wr(2'd0, 32'h101);
        repeat (3) @(posedge clk);
        wr(2'd0, 32'h101);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h101) begin
            failures++;
            $display("FAIL w1c_vs_set got=%h exp=00000101", v);
        end
        checks++;
        if (match_pulse !== 1'b1) begin
            failures++;
            $display("FAIL w1c_vs_set_pulse got=%b exp=1", match_pulse);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        // Enable irq without clearing MATCH; next match lands 3 edges later
        wr(2'd0, 32'h5);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL mid_irq_before got=%b exp=1", irq);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (match_pulse !== 1'b1) begin
            failures++;
            $display("FAIL mid_pulse_before got=%b exp=1", match_pulse);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0 || match_pulse !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_out got irq=%b pulse=%b exp 0 0", irq, match_pulse);
        end
        for (int i = 0; i < 4; i++) begin
            rd(i[1:0], v);
            checks++;
            if (v !== 32'h0) begin
                failures++;
                $display("FAIL mid_reset_read off=%0d got=%h exp=00000000", i, v);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_hold got=%h exp=00000000", v);
        end
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_prescaler();
        test_oneshot();
        test_wrap();
        test_collisions();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sm_timer.md
Name: sm_timer

Overview:
- Memory-mapped 32-bit compare timer; a bus slave hanging off sm_matrix beside sm_ram and sm_gpio.
- Shares the matrix bus (bAddr/bWe/bWData); returns bRData for the matrix read mux.
- Gives the CPU a prescaled up-counter with compare match, auto-reload or one-shot mode, a sticky match flag and a level irq output.

Parameters:
- BASE, 12'hbec, value of bAddr[15:4] that selects this block.
- PRESC_W, 16, width of the prescaler register and prescale counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- bAddr  input  32  bus address; byte offset in bAddr[3:2]
- bWe  input  1  bus write enable
- bWData  input  32  bus write data
- bRData  output  32  read data, combinational from bAddr
- irq  output  1  level interrupt = MATCH & IRQ_EN
- match_pulse  output  1  one-cycle pulse on each compare match

Behaviour:
- Select: sel = (bAddr[15:4] == BASE). Writes occur only when sel & bWe, on the rising clk edge. Reads are combinational, zero latency. When sel=0, bRData = 0.
- Register map (bAddr[3:2]):
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 IRQ_EN, bit8 MATCH. MATCH is read-only and write-1-to-clear. Other bits read 0.
  - 1 PRESC: PRESC_W bits, zero-extended on read.
  - 2 CMP: 32 bits.
  - 3 CNT: 32 bits, read/write.
- Reset (async, rst=1): all registers 0, prescale counter 0, irq=0, match_pulse=0, bRData=0 for any address.
- Prescaler:
  - pcnt counts 0..PRESC while EN=1.
  - tick = EN & (pcnt == PRESC); on tick, pcnt <= 0.
  - PRESC=0 gives a tick every cycle.
  - pcnt is held at 0 while EN=0.
  - Any write to PRESC clears pcnt in the same edge.
- Counter, on tick:
  - If CNT == CMP: CNT <= 0, MATCH <= 1, match_pulse <= 1 for one cycle, and if ONESHOT then EN <= 0.
  - Else CNT <= CNT + 1. This wraps 32'hFFFFFFFF to 0 without setting MATCH; it applies when software wrote CNT > CMP.
- Match period is (CMP+1)*(PRESC+1) cycles. CMP=0 matches on every tick.
- Simultaneous events:
  - CPU write to CNT on a tick edge: the written value wins and no increment or match is evaluated that edge.
  - MATCH set and W1C in the same edge: set wins, MATCH stays 1.
  - CTRL write sets EN/ONESHOT/IRQ_EN from bWData. If the same edge is a one-shot match, the hardware EN clear wins over a written EN=1.
  - Writing EN=0 stops counting at the next edge; CNT holds its value.
- irq and match_pulse are registered outputs with no combinational path from the bus.
- Reset mid-operation: everything returns immediately to reset values; no pending tick survives.

Decomposition:
- Add to sm_config.vh: SM_TIMER_BASE, register offset constants (CTRL/PRESC/CMP/CNT) and CTRL bit positions.
- One sub-module, sm_timer_prescaler:
  - Inputs: clk, rst, en, presc, clr.
  - Output: tick.
- Register file, counter and read mux stay in sm_timer.
- sm_matrix integration (instance plus a read-mux arm on BASE) is a separate change.

Test Plan:
- Reset, then read all four offsets -> 0. Read any address outside BASE -> bRData=0. irq=0.
- Write PRESC=0, CMP=3, CTRL=0x5 -> CNT goes 1,2,3,0 on consecutive cycles. match_pulse is high for one cycle exactly 4 cycles after EN, MATCH=1, irq=1. Write CTRL=0x105 -> MATCH=0, irq=0, counting continues.
- PRESC=2, CMP=1, EN -> match every 6 cycles. Write PRESC mid-count -> pcnt restarts, next tick PRESC+1 cycles after the write.
- ONESHOT: CTRL=0x3, CMP=2 -> single match after 3 ticks, then EN reads 0, CNT=0 and stays 0.
- Write CNT=0xFFFFFFFE with CMP=5, PRESC=0, EN -> CNT goes FFFFFFFF, 0, 1..5. MATCH sets only at CNT=5.
- Collisions:
  - Tick-edge write CNT=0x10 -> CNT=0x10.
  - W1C of MATCH on a match edge -> MATCH stays 1.
  - Assert rst while counting -> all outputs 0 immediately, before the next clk edge.
